// File: rtl/edge_detect_pkg.sv
// Shared types for the multi-channel edge detector.
// EDGE_DETECT_SYNC_EN (see edge_chan) adds an input synchroniser per channel.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10
  } edge_state_t;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_NONE = 2'b11
  } edge_mode_t;

endpackage

// File: rtl/edge_chan.sv
// One edge-detect channel: optional synchroniser, INIT/LOW/HIGH tracker, Mealy pulse,
// sticky flag and saturating event counter. Synchroniser enabled by EDGE_DETECT_SYNC_EN.
module edge_chan
  import edge_detect_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             pulse,
  output logic             sticky,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic level;

`ifdef EDGE_DETECT_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = in_bit;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign level = sync2_q;
`else
  assign level = in_bit;
`endif

  edge_state_t      state_q, state_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_det, fall_det;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = level ? ST_HIGH : ST_LOW;
      ST_LOW:  if (level)  state_d = ST_HIGH;
      ST_HIGH: if (!level) state_d = ST_LOW;
      default: state_d = ST_INIT;
    endcase
  end

  // INIT never reports an edge, so an input already high at reset is not a rise.
  always_comb begin
    rise_det = (state_q == ST_LOW)  &&  level;
    fall_det = (state_q == ST_HIGH) && !level;
    pulse    = 1'b0;
    case (edge_mode_t'(mode))
      MODE_RISE: pulse = rise_det;
      MODE_FALL: pulse = fall_det;
      MODE_BOTH: pulse = rise_det | fall_det;
      default:   pulse = 1'b0;
    endcase
  end

  // A clear coinciding with an event keeps that event.
  always_comb begin
    sticky_d = sticky_q | pulse;
    cnt_d    = cnt_q;
    if (clr) begin
      sticky_d = pulse;
      cnt_d    = pulse ? CNT_W'(1) : '0;
    end else if (pulse && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sticky = sticky_q;
  assign count  = cnt_q;

endmodule

// File: rtl/edge_detect_multi.sv
// N-channel edge detector: one edge_chan per input bit plus the counter read mux.
// Input synchronisers are enabled by defining EDGE_DETECT_SYNC_EN.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 8,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     pulse,
  output logic [N-1:0]     sticky,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_chan
    edge_chan #(.CNT_W(CNT_W)) u_chan (
      .clk    (clk),
      .rst    (rst),
      .in_bit (in[i]),
      .mode   (mode),
      .clr    (clr),
      .pulse  (pulse[i]),
      .sticky (sticky[i]),
      .count  (cnt_arr[i])
    );
  end

  // Unmatched select values (sel >= N) read as zero.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) count = cnt_arr[i];
    end
  end

endmodule
